// File: rtl/lcd_text_writer.sv
// HD44780 text writer over a 4-bit bus: power-up init, then streams characters
// and newline / carriage-return / form-feed controls with cursor tracking.
//
// state        | meaning
// PWR_WAIT     | power-up delay after reset
// INIT         | 4-bit init nibbles followed by the configuration bytes
// IDLE         | ready for a byte (in_ready = 1)
// SEND_ADDR    | DDRAM address command (cursor move or wrap re-address)
// SEND_BYTE    | character data byte or clear-display command
module lcd_text_writer #(
   parameter int FREQ     = 50_000_000,
   parameter int COLS     = 16,
   parameter int ROWS     = 2,
   parameter int CURSOR   = 0,
   parameter int BLINK    = 0,
   parameter int T_PWR_US = 15000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       byte_done,
   output logic       init_done,
   output logic [1:0] cur_row,
   output logic [5:0] cur_col,
   output logic [3:0] LCD_D,
   output logic       LCD_RS,
   output logic       LCD_E
);

   localparam int T1US   = (FREQ / 1_000_000 < 1) ? 1 : FREQ / 1_000_000;
   localparam int PWR_US = (T_PWR_US < 1) ? 1 : T_PWR_US;
   localparam int MAX_US = (PWR_US > 4100) ? PWR_US : 4100;
   localparam int CW     = $clog2(MAX_US * T1US + 1);

   localparam logic [CW-1:0] C_T1  = CW'(T1US - 1);
   localparam logic [CW-1:0] C_PWR = CW'(PWR_US * T1US - 1);

   localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);
   localparam logic [5:0] LAST_COL = 6'(COLS - 1);
   localparam logic [7:0] COLS8    = 8'(COLS);
   localparam logic [7:0] FS_CMD   = (ROWS > 1) ? 8'h28 : 8'h20;
   localparam logic [7:0] DISP_ON  = 8'h0C | ((CURSOR != 0) ? 8'h02 : 8'h00)
                                           | ((BLINK != 0) ? 8'h01 : 8'h00);

   typedef enum logic [2:0] {
      ST_PWR_WAIT,
      ST_INIT,
      ST_IDLE,
      ST_SEND_ADDR,
      ST_SEND_BYTE
   } state_t;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_EHI,
      PH_DLY
   } phase_t;

   state_t        r_state, w_next;
   phase_t        r_ph;
   logic [CW-1:0] r_cnt, r_dly, w_dly_cyc;
   logic [3:0]    r_step, w_n_steps;
   logic [3:0]    r_lcd_d, w_nib;
   logic          r_lcd_rs, r_lcd_e, w_rs;
   logic [1:0]    r_row, w_row_inc;
   logic [5:0]    r_col;
   logic          r_wrap, r_then_data, r_rs;
   logic [7:0]    r_byte, r_addr, w_xb;
   logic          r_init_done, r_byte_done;
   logic [12:0]   w_dly_us;
   logic          w_busy, w_more, w_load, w_seq_end, w_accept, w_ready;
   logic          w_eng_idle, w_nib_done;

   function automatic logic [7:0] row_base(input logic [1:0] row);
      case (row)
         2'd0:    row_base = 8'h00;
         2'd1:    row_base = 8'h40;
         2'd2:    row_base = COLS8;
         default: row_base = 8'h40 + COLS8;
      endcase
   endfunction

   assign w_eng_idle = (r_ph == PH_IDLE);
   assign w_nib_done = (r_ph == PH_DLY) && (r_cnt == '0);
   assign w_row_inc  = (r_row == LAST_ROW) ? 2'd0 : r_row + 2'd1;
   assign w_dly_cyc  = CW'(32'(w_dly_us) * T1US - 1);

   // nibble, RS and post-strobe delay for the current step of the active sequence
   always_comb begin
      w_xb = r_byte;
      w_rs = r_rs;
      case (r_state)
         ST_INIT: begin
            w_rs = 1'b0;
            case (r_step)
               4'd4, 4'd5:   w_xb = FS_CMD;
               4'd6, 4'd7:   w_xb = 8'h08;
               4'd8, 4'd9:   w_xb = 8'h01;
               4'd10, 4'd11: w_xb = 8'h06;
               default:      w_xb = DISP_ON;
            endcase
         end
         ST_SEND_ADDR: begin
            w_xb = r_addr;
            w_rs = 1'b0;
         end
         default: ;
      endcase
      w_nib = r_step[0] ? w_xb[3:0] : w_xb[7:4];
      if (!r_step[0])
         w_dly_us = 13'd10;
      else if (!w_rs && (w_xb == 8'h01 || w_xb == 8'h02))
         w_dly_us = 13'd3000;
      else
         w_dly_us = 13'd53;
      if (r_state == ST_INIT && r_step < 4'd4) begin
         w_nib    = (r_step == 4'd3) ? 4'h2 : 4'h3;
         w_dly_us = (r_step == 4'd0) ? 13'd4100 : 13'd100;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) r_state <= ST_PWR_WAIT;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_PWR_WAIT:  if (r_cnt == '0) w_next = ST_INIT;
         ST_INIT:      if (w_seq_end) w_next = ST_IDLE;
         ST_IDLE: begin
            if (w_accept) begin
               if (in_data == 8'h0A || in_data == 8'h0D) w_next = ST_SEND_ADDR;
               else if (in_data == 8'h0C)                w_next = ST_SEND_BYTE;
               else if (r_wrap)                          w_next = ST_SEND_ADDR;
               else                                      w_next = ST_SEND_BYTE;
            end
         end
         ST_SEND_ADDR: if (w_seq_end) w_next = r_then_data ? ST_SEND_BYTE : ST_IDLE;
         ST_SEND_BYTE: if (w_seq_end) w_next = ST_IDLE;
         default:      w_next = ST_PWR_WAIT;
      endcase
   end

   always_comb begin
      w_busy    = (r_state == ST_INIT) || (r_state == ST_SEND_ADDR) ||
                  (r_state == ST_SEND_BYTE);
      w_n_steps = (r_state == ST_INIT) ? 4'd14 : 4'd2;
      w_more    = (r_step < w_n_steps);
      w_load    = w_busy && (w_eng_idle || w_nib_done) && w_more;
      w_seq_end = w_busy && w_nib_done && !w_more;
      w_ready   = (r_state == ST_IDLE);
      w_accept  = w_ready && in_valid;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt       <= C_PWR;
         r_dly       <= '0;
         r_ph        <= PH_IDLE;
         r_step      <= '0;
         r_lcd_d     <= '0;
         r_lcd_rs    <= 1'b0;
         r_lcd_e     <= 1'b0;
         r_row       <= '0;
         r_col       <= '0;
         r_wrap      <= 1'b0;
         r_then_data <= 1'b0;
         r_rs        <= 1'b0;
         r_byte      <= '0;
         r_addr      <= '0;
         r_init_done <= 1'b0;
         r_byte_done <= 1'b0;
      end else begin
         r_byte_done <= w_seq_end && ((r_state == ST_SEND_BYTE) ||
                        (r_state == ST_SEND_ADDR && !r_then_data));
         if (r_state == ST_INIT && w_seq_end) r_init_done <= 1'b1;

         if (r_state != w_next) r_step <= '0;
         else if (w_load)       r_step <= r_step + 4'd1;

         // strobe engine: setup -> E high -> post delay, chaining directly into the next nibble
         if (w_load) begin
            r_lcd_d  <= w_nib;
            r_lcd_rs <= w_rs;
            r_dly    <= w_dly_cyc;
            r_cnt    <= C_T1;
            r_ph     <= PH_SETUP;
         end else begin
            case (r_ph)
               PH_IDLE:  if (r_state == ST_PWR_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
               PH_SETUP: begin
                  if (r_cnt == '0) begin
                     r_ph    <= PH_EHI;
                     r_lcd_e <= 1'b1;
                     r_cnt   <= C_T1;
                  end else r_cnt <= r_cnt - 1'b1;
               end
               PH_EHI: begin
                  if (r_cnt == '0) begin
                     r_ph    <= PH_DLY;
                     r_lcd_e <= 1'b0;
                     r_cnt   <= r_dly;
                  end else r_cnt <= r_cnt - 1'b1;
               end
               default: begin
                  if (r_cnt == '0) r_ph  <= PH_IDLE;
                  else             r_cnt <= r_cnt - 1'b1;
               end
            endcase
         end

         if (w_accept) begin
            r_then_data <= 1'b0;
            r_wrap      <= 1'b0;
            case (in_data)
               8'h0A: begin
                  r_col  <= '0;
                  if (!r_wrap) r_row <= w_row_inc;
                  r_addr <= 8'h80 | row_base(r_wrap ? r_row : w_row_inc);
               end
               8'h0D: begin
                  r_col  <= '0;
                  r_addr <= 8'h80 | row_base(r_row);
               end
               8'h0C: begin
                  r_byte <= 8'h01;
                  r_rs   <= 1'b0;
                  r_row  <= '0;
                  r_col  <= '0;
               end
               default: begin
                  r_byte      <= in_data;
                  r_rs        <= 1'b1;
                  r_then_data <= 1'b1;
                  r_addr      <= 8'h80 | (row_base(r_row) + {2'b00, r_col});
                  if (r_col == LAST_COL) begin
                     r_col  <= '0;
                     r_row  <= w_row_inc;
                     r_wrap <= 1'b1;
                  end else begin
                     r_col <= r_col + 6'd1;
                  end
               end
            endcase
         end
      end
   end

   assign in_ready  = w_ready;
   assign byte_done = r_byte_done;
   assign init_done = r_init_done;
   assign cur_row   = r_row;
   assign cur_col   = r_col;
   assign LCD_D     = r_lcd_d;
   assign LCD_RS    = r_lcd_rs;
   assign LCD_E     = r_lcd_e;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench for lcd_text_writer at 4 MHz (T1US = 4): init order, data,
// wrap, newline / CR / form feed and mid-transfer reset.
module tb_lcd_text_writer;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready, byte_done, init_done, LCD_RS, LCD_E;
   logic [1:0] cur_row;
   logic [5:0] cur_col;
   logic [3:0] LCD_D;

   always #5 CLK = ~CLK;

   lcd_text_writer #(
      .FREQ(4_000_000), .COLS(16), .ROWS(2), .CURSOR(0), .BLINK(0), .T_PWR_US(15)
   ) dut (
      .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .byte_done(byte_done), .init_done(init_done),
      .cur_row(cur_row), .cur_col(cur_col),
      .LCD_D(LCD_D), .LCD_RS(LCD_RS), .LCD_E(LCD_E)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // strobed nibbles {RS, D} captured on each E falling edge
   logic [4:0] mon_q[$];
   logic [4:0] exp_q[$];
   logic       e_prev = 1'b0;
   int         e_run = 0;
   int         e_width = 0;
   int         bd_cnt = 0;

   always @(negedge CLK) begin
      if (byte_done) bd_cnt++;
      if (LCD_E) e_run++;
      else if (e_prev) begin
         mon_q.push_back({LCD_RS, LCD_D});
         e_width = e_run;
         e_run   = 0;
      end
      e_prev = LCD_E;
   end

   task automatic check_nibs(input string tag);
      check({tag, "_cnt"}, mon_q.size(), exp_q.size());
      foreach (exp_q[i])
         check($sformatf("%s_%0d", tag, i),
               (i < mon_q.size()) ? 32'(mon_q[i]) : 32'hFFFF, 32'(exp_q[i]));
      mon_q.delete();
   endtask

   task automatic send(input logic [7:0] b, output int busy, output logic bd_at_rdy);
      int guard;
      guard = 0;
      busy  = 0;
      in_data  = b;
      in_valid = 1'b1;
      @(posedge CLK);
      #1 in_valid = 1'b0;
      @(negedge CLK);
      while (!in_ready && guard < 20000) begin
         busy++;
         guard++;
         @(negedge CLK);
      end
      if (guard >= 20000) check("send_timeout", 32'(guard), 32'd0);
      bd_at_rdy = byte_done;
      #1;
   endtask

   initial begin
      int   busy;
      int   guard;
      logic bd;

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_e", LCD_E, 1'b0);
      check("rst_rs", LCD_RS, 1'b0);
      check("rst_d", LCD_D, 4'h0);
      check("rst_ready", in_ready, 1'b0);
      check("rst_bd", byte_done, 1'b0);
      check("rst_init", init_done, 1'b0);
      check("rst_row", cur_row, 2'd0);
      check("rst_col", cur_col, 6'd0);

      // in_valid held high through init must not be taken before init_done
      RST = 1'b0;
      mon_q.delete();
      in_data  = 8'h41;
      in_valid = 1'b1;
      guard = 0;
      while (!init_done && guard < 40000) begin
         @(negedge CLK);
         guard++;
      end
      in_valid = 1'b0;
      #1;
      check("init_in_time", 32'(guard < 40000), 32'd1);
      check("init_ready", in_ready, 1'b1);
      exp_q = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00,
                5'h08, 5'h00, 5'h01, 5'h00, 5'h06, 5'h00, 5'h0C};
      check_nibs("init_nib");

      bd_cnt = 0;
      send(8'h41, busy, bd);
      check("a_busy", busy, 269);
      check("a_bd_ready", bd, 1'b1);
      check("a_bd_cnt", bd_cnt, 1);
      check("a_e_width", e_width, 4);
      check("a_col", cur_col, 6'd1);
      check("a_row", cur_row, 2'd0);
      exp_q = '{5'h14, 5'h11};
      check_nibs("a_nib");

      repeat (15) send(8'h41, busy, bd);
      check("wrap_row", cur_row, 2'd1);
      check("wrap_col", cur_col, 6'd0);
      mon_q.delete();

      send(8'h42, busy, bd);
      exp_q = '{5'h0C, 5'h00, 5'h14, 5'h12};
      check_nibs("b_nib");
      check("b_col", cur_col, 6'd1);
      check("b_row", cur_row, 2'd1);

      repeat (14) send(8'h41, busy, bd);
      check("r1_col15", cur_col, 6'd15);
      send(8'h41, busy, bd);
      check("last_wrap_row", cur_row, 2'd0);
      check("last_wrap_col", cur_col, 6'd0);
      mon_q.delete();

      send(8'h0A, busy, bd);
      exp_q = '{5'h08, 5'h00};
      check_nibs("nl_wrap_nib");
      check("nl_wrap_busy", busy, 269);
      check("nl_wrap_bd", bd, 1'b1);
      check("nl_wrap_row", cur_row, 2'd0);
      check("nl_wrap_col", cur_col, 6'd0);

      send(8'h41, busy, bd);
      mon_q.delete();
      send(8'h0D, busy, bd);
      exp_q = '{5'h08, 5'h00};
      check_nibs("cr_nib");
      check("cr_col", cur_col, 6'd0);
      check("cr_row", cur_row, 2'd0);

      send(8'h0A, busy, bd);
      exp_q = '{5'h0C, 5'h00};
      check_nibs("nl_nib");
      check("nl_row", cur_row, 2'd1);
      check("nl_col", cur_col, 6'd0);

      bd_cnt = 0;
      send(8'h0C, busy, bd);
      exp_q = '{5'h00, 5'h01};
      check_nibs("ff_nib");
      check("ff_busy", busy, 12057);
      check("ff_bd_cnt", bd_cnt, 1);
      check("ff_row", cur_row, 2'd0);
      check("ff_col", cur_col, 6'd0);

      // reset while E is high during a data byte
      in_data  = 8'h41;
      in_valid = 1'b1;
      @(posedge CLK);
      #1 in_valid = 1'b0;
      guard = 0;
      while (!LCD_E && guard < 100) begin
         @(negedge CLK);
         guard++;
      end
      check("mid_e_high", LCD_E, 1'b1);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      check("mid_rst_e", LCD_E, 1'b0);
      check("mid_rst_init", init_done, 1'b0);
      check("mid_rst_ready", in_ready, 1'b0);
      check("mid_rst_col", cur_col, 6'd0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      mon_q.delete();
      guard = 0;
      while (mon_q.size() == 0 && guard < 200) begin
         @(negedge CLK);
         guard++;
      end
      #1;
      check("reinit_first_nib", (mon_q.size() > 0) ? 32'(mon_q[0]) : 32'hFFFF, 32'h03);
      check("reinit_not_done", init_done, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lcd_text_writer.md
LCD_TEXT_WRITER -- requirements
Module: lcd_text_writer

Interface
REQ-001 Parameter FREQ, default 50_000_000, clock frequency in Hz; T1US = FREQ/1_000_000 cycles, integer, at least 1.
REQ-002 Parameter COLS, default 16, display columns, legal range 1..40.
REQ-003 Parameter ROWS, default 2, display rows; legal values are 1, 2 or 4.
REQ-004 Parameter CURSOR, default 0, sets display-on command bit C.
REQ-005 Parameter BLINK, default 0, sets display-on command bit B.
REQ-006 Parameter T_PWR_US, default 15000, power-up wait in microseconds.
REQ-007 CLK  in  1  sole clock; all logic on rising edge.
REQ-008 RST  in  1  synchronous, active-high reset.
REQ-009 in_data  in  8  character or control byte.
REQ-010 in_valid  in  1  in_data valid.
REQ-011 in_ready  out  1  block accepts a byte this cycle.
REQ-012 byte_done  out  1  one-cycle pulse when the last LCD transfer for a byte completes.
REQ-013 init_done  out  1  HD44780 4-bit initialisation complete.
REQ-014 cur_row  out  2  current cursor row.
REQ-015 cur_col  out  6  current cursor column.
REQ-016 LCD_D  out  4  LCD data nibble (DB7..DB4).
REQ-017 LCD_RS  out  1  register select: 0 = command, 1 = data.
REQ-018 LCD_E  out  1  LCD enable strobe.

Function
REQ-019 Nibble transfer: drive LCD_RS and LCD_D, wait T1US cycles, hold LCD_E high for T1US cycles, drop LCD_E, then wait the nibble delay; LCD_RS and LCD_D stay stable throughout.
REQ-020 Byte transfer: high nibble first with a 10 us delay, then low nibble with a 53 us delay.
REQ-021 Exception: commands 0x01 and 0x02 use a 3000 us low-nibble delay.
REQ-022 Init FSM order: wait T_PWR_US.
- Single nibbles: 0x3 (4100 us), 0x3 (100 us), 0x3 (100 us), 0x2 (100 us).
- Bytes: function set (0x28 if ROWS>1, else 0x20), 0x08, 0x01, 0x06, then 0x0C|(CURSOR<<1)|BLINK.
REQ-023 init_done rises in the cycle after the final init delay expires; in_ready rises with it.
REQ-024 FSM states: PWR_WAIT, INIT, IDLE, SEND_ADDR, SEND_BYTE.
- in_ready = 1 only in IDLE.
- A byte is accepted on in_valid & in_ready; in_ready drops the next cycle.
REQ-025 DDRAM row base addresses: row0 = 0x00, row1 = 0x40, row2 = COLS, row3 = 0x40+COLS.
- Address command = 0x80 | (base + col).
REQ-026 Byte 0x0A (newline):
- row ← (row+1) mod ROWS, col ← 0; send address command.
- If wrap_pending = 1, the row does not advance; only the address command is sent and wrap_pending clears.
REQ-027 Byte 0x0D (carriage return): col ← 0; send address command for the current row; clears wrap_pending.
REQ-028 Byte 0x0C (form feed): send command 0x01; row ← 0, col ← 0; clears wrap_pending.
REQ-029 Any other byte is written as data (RS=1), then col increments.
- When col reaches COLS: col ← 0, row ← (row+1) mod ROWS, wrap_pending ← 1.
REQ-030 A data byte accepted while wrap_pending = 1 first sends the address command, then the data byte, in one busy window; wrap_pending clears.
REQ-031 Last-row wrap returns to row 0; no scrolling is performed.
REQ-032 byte_done pulses in the same cycle in_ready reasserts.
REQ-033 Busy window for a plain data byte: in_ready low for exactly 4*T1US + 63*T1US + 1 cycles.
REQ-034 All delay counters are sized for the largest delay at the given FREQ; no overflow.

Reset
REQ-035 While RST is sampled high, outputs are forced to:
- LCD_E = 0, LCD_RS = 0, LCD_D = 0
- in_ready = 0, byte_done = 0, init_done = 0
- cur_row = 0, cur_col = 0, wrap_pending = 0
- FSM = PWR_WAIT
REQ-036 RST asserted mid-transfer aborts it: LCD_E is low at the next edge, and the full init sequence restarts after RST is released.
REQ-037 in_valid is ignored while init_done = 0.

Verification (FREQ=4_000_000, T1US=4, T_PWR_US=15, COLS=16, ROWS=2)
REQ-038 Reset release -> LCD_E falling-edge nibble sequence is 3,3,3,2,2,8,0,8,0,1,0,6,0,C; init_done then rises with in_ready=1.
REQ-039 Send 0x41 -> nibbles 4,1 with RS=1; E high for 4 cycles; in_ready low for 269 cycles; byte_done pulses once; cur_col=1.
REQ-040 Send 16 x 0x41, then 0x42 -> after the 16th byte row=1, col=0; the 0x42 window carries command nibbles C,0 (0xC0) then data 4,2; cur_col=1.
REQ-041 At row=1, col=15 send 0x41, then 0x0A -> the 0x0A emits only 0x80 (row 0 after wrap, no extra advance); cur_row=0, cur_col=0.
REQ-042 Send 0x0C -> command nibbles 0,1; busy window uses the 3000 us delay; cur_row=0, cur_col=0.
REQ-043 Assert RST while LCD_E=1 during a data byte -> LCD_E=0 next cycle, init_done=0, and the full init sequence repeats.
